seq_divider6: RTL and testbench
===============================

# seq_divider6

Iterative unsigned restoring divider. Computes quotient and remainder of two WIDTH-bit operands, one quotient bit per clock, using a start/done handshake. It is the inverse companion to the team's ripple adder datapath and serves as the arithmetic back-end for lab-board calculator and display logic.

## Interface
Parameters:
- WIDTH, 6, operand, quotient and remainder width

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  asynchronous, active-high; clears all state
- start  input  1  request a new division; sampled only in IDLE or DONE
- dividend  input  WIDTH  unsigned dividend; sampled in the start cycle
- divisor  input  WIDTH  unsigned divisor; sampled in the start cycle
- busy  output  1  high while an operation is in progress (BUSY state)
- done  output  1  one-cycle pulse; quotient and remainder are valid
- quotient  output  WIDTH  result quotient; held until the next accepted start
- remainder  output  WIDTH  result remainder; held until the next accepted start
- div_zero  output  1  divisor was zero; valid with done (tied 0 when the feature is compiled out)

## Operation
- FSM has three states: IDLE, BUSY, DONE.
  - IDLE: on start, capture dividend into shift register A, divisor into D; clear R (WIDTH+1 bits) and step counter; go to BUSY.
  - BUSY: one step per cycle:
    - R' = {R[WIDTH-1:0], A[WIDTH-1]}; A shifts left.
    - T = R' − {1'b0, D} at WIDTH+1 bits.
    - If there is no borrow: R = T and the shifted-in quotient bit is 1. Otherwise: R = R' and the bit is 0.
    - The quotient bits shift into A's LSB.
    - After WIDTH steps, go to DONE.
  - DONE: done = 1, quotient = A, remainder = R[WIDTH-1:0]. Next state is BUSY if start is high, else IDLE.
- start during BUSY is ignored. It is not queued.
- start in DONE is accepted in that same cycle (back-to-back operation).
- Divisor 0 with the algorithm running produces quotient = all ones and remainder = dividend.
- Outputs hold their last result through IDLE and BUSY.
- Arithmetic is unsigned only. No overflow is possible.

## Timing
- Reset values: busy = 0, done = 0, quotient = 0, remainder = 0, div_zero = 0, state = IDLE.
- start accepted at edge t → busy high from t+1 through t+WIDTH → done high for one cycle at t+WIDTH+1 (7 cycles for WIDTH = 6).
- busy and done are never high together.
- Reset asserted mid-operation aborts immediately (asynchronously) to IDLE with all outputs cleared. The first start after reset release behaves normally.

## Configuration
- DIVZERO_CHECK_EN defined:
  - A start with divisor == 0 goes directly from IDLE/DONE to DONE at t+1, skipping BUSY.
  - It produces quotient = all ones, remainder = dividend, div_zero = 1 with done.
  - div_zero clears on the next accepted start.
- DIVZERO_CHECK_EN undefined:
  - Divide-by-zero takes the full WIDTH+1 latency, giving the same quotient/remainder.
  - div_zero is constant 0.

## Structure
- Package div_pkg holds:
  - the state enum (IDLE, BUSY, DONE)
  - DIV_WIDTH_DEFAULT = 6
  - the counter width constant, $clog2(WIDTH+1)
- One combinational sub-module, restore_step:
  - inputs: WIDTH+1-bit partial remainder, WIDTH-bit divisor
  - outputs: next remainder and quotient bit
  - built as a ripple subtract with borrow out
- The top level holds the FSM, counter, and A/R/D registers.

## Test plan
- 45 / 7, start at t → done only at t+7, quotient = 6, remainder = 3, div_zero = 0, busy high t+1..t+6.
- 63 / 1 then 5 / 9, with the second start issued during the DONE cycle → 63 r 0, then 0 r 5 exactly 7 cycles later, with no idle gap.
- 37 / 0 → quotient = 63, remainder = 37. With DIVZERO_CHECK_EN: done at t+1 and div_zero = 1. Without it: done at t+7 and div_zero = 0.
- start pulsed with 10 / 3 at t+3 during a 50 / 6 operation → done at t+7 with 8 r 2; the second request produces no done.
- reset asserted at t+4 of 60 / 4 → all outputs 0 immediately, state IDLE; no done. A following 60 / 4 returns 15 r 0.
- Exhaustive sweep of all 64×63 nonzero-divisor pairs → quotient and remainder match a / b and a % b.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIV_WIDTH_DEFAULT = 6;
  localparam int DIV_CNT_W         = $clog2(DIV_WIDTH_DEFAULT + 1);

  // Step counter must hold the value WIDTH, hence WIDTH+1 states.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_divider6_restore_step.sv
// One restoring-division step: ripple subtract of the divisor from the shifted
// partial remainder, keeping the difference only when no borrow comes out.
module restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH:0]   rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0]   sub_b;
  logic [WIDTH:0]   diff;
  logic [WIDTH+1:0] brw;

  assign sub_b  = {1'b0, div_i};
  assign brw[0] = 1'b0;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_sub
    assign diff[i]    = rem_i[i] ^ sub_b[i] ^ brw[i];
    assign brw[i + 1] = (~rem_i[i] & sub_b[i]) | (~(rem_i[i] ^ sub_b[i]) & brw[i]);
  end

  assign qbit_o = ~brw[WIDTH+1];
  assign rem_o  = qbit_o ? diff : rem_i;

endmodule

// File: rtl/seq_divider6.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Optional DIVZERO_CHECK_EN: divide-by-zero short-cuts straight to DONE and flags div_zero.
module seq_divider6
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, d_q, quot_q, rem_q;
  logic [WIDTH:0]   r_q, r_shift, r_next;
  logic [CNT_W-1:0] cnt_q;
  logic             qbit, accept, zero_start, last_step;
  logic [WIDTH-1:0] a_next;

  assign accept    = start && (state_q == IDLE || state_q == DONE);
  assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
  assign r_shift   = {r_q[WIDTH-1:0], a_q[WIDTH-1]};
  assign a_next    = {a_q[WIDTH-2:0], qbit};

`ifdef DIVZERO_CHECK_EN
  assign zero_start = accept && (divisor == '0);
`else
  assign zero_start = 1'b0;
`endif

  restore_step #(.WIDTH(WIDTH)) u_step (
    .rem_i  (r_shift),
    .div_i  (d_q),
    .rem_o  (r_next),
    .qbit_o (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) state_d = zero_start ? DONE : BUSY;
        else        state_d = IDLE;
      end
      BUSY:    if (last_step) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == BUSY);
    done = (state_q == DONE);
  end

  // Result registers load only on completion, so they hold through IDLE/BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q    <= '0;
      d_q    <= '0;
      r_q    <= '0;
      cnt_q  <= '0;
      quot_q <= '0;
      rem_q  <= '0;
    end else if (accept) begin
      a_q   <= dividend;
      d_q   <= divisor;
      r_q   <= '0;
      cnt_q <= '0;
      if (zero_start) begin
        quot_q <= '1;
        rem_q  <= dividend;
      end
    end else if (state_q == BUSY) begin
      a_q   <= a_next;
      r_q   <= r_next;
      cnt_q <= cnt_q + CNT_W'(1);
      if (last_step) begin
        quot_q <= a_next;
        rem_q  <= r_next[WIDTH-1:0];
      end
    end
  end

`ifdef DIVZERO_CHECK_EN
  logic dz_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       dz_q <= 1'b0;
    else if (accept) dz_q <= zero_start;
  end
  assign div_zero = dz_q;
`else
  assign div_zero = 1'b0;
`endif

  assign quotient  = quot_q;
  assign remainder = rem_q;

endmodule

// File: tb/tb_seq_divider6.sv
// Directed + exhaustive bench for seq_divider6 with a result scoreboard.
module tb_seq_divider6;
  localparam int W = 6;
`ifdef DIVZERO_CHECK_EN
  localparam bit ZCHK = 1'b1;
`else
  localparam bit ZCHK = 1'b0;
`endif

  logic         clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [W-1:0] dividend = '0, divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           due;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0, fails = 0, cyc = 0;

  seq_divider6 #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Called at a negedge; start is sampled at the following posedge.
  task automatic issue(input int a, input int b, input string tag);
    exp_t e;
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    e.tag = tag;
    if (b == 0) begin
      e.q   = '1;
      e.r   = W'(a);
      e.dz  = ZCHK;
      e.due = cyc + (ZCHK ? 1 : W + 1);
    end else begin
      e.q   = W'(a / b);
      e.r   = W'(a % b);
      e.dz  = 1'b0;
      e.due = cyc + W + 1;
    end
    sb.push_back(e);
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("busy_done_excl", {31'd0, busy & done}, 0);
      if (done) begin
        check("done_expected", {31'd0, sb.size() != 0}, 1);
        if (sb.size() != 0) begin
          mon_e = sb.pop_front();
          check({mon_e.tag, "_quot"}, quotient, mon_e.q);
          check({mon_e.tag, "_rem"}, remainder, mon_e.r);
          check({mon_e.tag, "_dz"}, div_zero, mon_e.dz);
          check({mon_e.tag, "_latency"}, cyc, mon_e.due);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_quot", quotient, 0);
    check("rst_rem", remainder, 0);
    check("rst_dz", div_zero, 0);
    reset = 1'b0;

    // 45 / 7: busy for exactly W cycles, done on the 7th
    @(negedge clk);
    issue(45, 7, "t45_7");
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      start = 1'b0;
      check("t45_7_busy", busy, 1);
      check("t45_7_nodone", done, 0);
    end
    wait_drain(10);

    // 63 / 1 then 5 / 9 started in the DONE cycle
    @(negedge clk);
    issue(63, 1, "t63_1");
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t63_1_reached_done", done, 1);
    issue(5, 9, "t5_9_b2b");
    @(negedge clk);
    start = 1'b0;
    check("t5_9_busy_no_gap", busy, 1);
    wait_drain(20);

    // divide by zero
    @(negedge clk);
    issue(37, 0, "t37_0");
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);

    // start during BUSY must be ignored
    @(negedge clk);
    issue(50, 6, "t50_6");
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 6'd10;
    divisor  = 6'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);
    repeat (10) @(negedge clk);

    // reset mid-operation
    @(negedge clk);
    issue(60, 4, "t60_4_abort");
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_quot", quotient, 0);
    check("abort_rem", remainder, 0);
    check("abort_dz", div_zero, 0);
    sb.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    issue(60, 4, "t60_4");
    @(negedge clk);
    start = 1'b0;
    wait_drain(20);

    // exhaustive nonzero-divisor sweep
    for (int a = 0; a < (1 << W); a++) begin
      for (int b = 1; b < (1 << W); b++) begin
        @(negedge clk);
        issue(a, b, "sweep");
        @(negedge clk);
        start = 1'b0;
        wait_drain(20);
      end
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
